maze_gen: RTL and testbench

- Upstream producer of the 1200-bit maze map (40 columns x 30 rows, 1 = wall, 0 = path) consumed by the VGA draw stage.
- On a start pulse, builds a random perfect maze sized by difficulty level using the binary-tree algorithm. Carves one cell per clock, driven by a free-running 16-bit LFSR.
- Holds the finished map and level stable until the next start.

---
 rtl/maze_gen.sv | 134 +++++++++++++
 tb/tb_maze_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/maze_gen.sv
`default_nettype none
// ============================================================================
// Module   : maze_gen
// Purpose  : Binary-tree perfect-maze generator; carves one cell per clock.
// Revision : 1.0
// ============================================================================
module maze_gen #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          MAP_W = 40,
    parameter int          MAP_H = 30
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Start,
    input  logic [1:0]             i_MazeLevel,
    output logic [MAP_W*MAP_H-1:0] o_MazeMap,
    output logic [1:0]             o_MazeLevel,
    output logic                   o_Busy,
    output logic                   o_fGen_Done
);

    localparam int MAP_N = MAP_W * MAP_H;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_CARVE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [MAP_N-1:0] map_q, map_d;
    logic [1:0]       level_q, level_d;
    logic [5:0]       x_q, x_d;
    logic [4:0]       y_q, y_d;
    logic [15:0]      lfsr_q, lfsr_d;

    logic [5:0]       w_wa;
    logic [4:0]       w_ha;
    logic [10:0]      w_idx;
    logic             w_origin;
    logic             w_go_north;
    logic             w_last_col;
    logic             w_last_row;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        case (level_q)
            2'b00:   begin w_wa = 6'd16;      w_ha = 5'd12;      end
            2'b01:   begin w_wa = 6'd32;      w_ha = 5'd24;      end
            default: begin w_wa = 6'(MAP_W); w_ha = 5'(MAP_H); end
        endcase
    end

    assign w_idx      = 11'(y_q) * 11'(MAP_W) + 11'(x_q);
    assign w_origin   = (x_q == 6'd1) && (y_q == 5'd1);
    // First row can only go west, first column only north; elsewhere the LFSR picks
    assign w_go_north = (y_q != 5'd1) && ((x_q == 6'd1) || lfsr_q[0]);
    assign w_last_col = (x_q == w_wa - 6'd1);
    assign w_last_row = (y_q == w_ha - 5'd1);

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        level_d = level_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    level_d = (i_MazeLevel == 2'b11) ? 2'b10 : i_MazeLevel;
                    x_d     = 6'd1;
                    y_d     = 5'd1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                map_d   = '1;
                state_d = ST_CARVE;
            end
            ST_CARVE: begin
                map_d[w_idx] = 1'b0;
                if (!w_origin) begin
                    if (w_go_north) begin
                        map_d[w_idx - 11'(MAP_W)] = 1'b0;
                    end else begin
                        map_d[w_idx - 11'd1] = 1'b0;
                    end
                end
                if (w_last_col) begin
                    x_d = 6'd1;
                    y_d = y_q + 5'd2;
                    if (w_last_row) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    x_d = x_q + 6'd2;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q <= ST_IDLE;
            map_q   <= '1;
            level_q <= 2'b00;
            x_q     <= 6'd1;
            y_q     <= 5'd1;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            level_q <= level_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign o_MazeMap   = map_q;
    assign o_MazeLevel = level_q;
    assign o_Busy      = (state_q == ST_CLEAR) || (state_q == ST_CARVE);
    assign o_fGen_Done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_maze_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_maze_gen
// Purpose  : Directed self-checking bench for maze_gen with a reference maze model.
// Revision : 1.0
// ============================================================================
module tb_maze_gen;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          N    = 1200;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   lvl   = 2'b00;
    logic [N-1:0] map;
    logic [1:0]   lvl_o;
    logic         busy;
    logic         done;
    logic [15:0]  m_lfsr;

    int total = 0;
    int bad   = 0;

    maze_gen dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Start     (start),
        .i_MazeLevel (lvl),
        .o_MazeMap   (map),
        .o_MazeLevel (lvl_o),
        .o_Busy      (busy),
        .o_fGen_Done (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference LFSR, kept in lockstep with the design's free-running one
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= adv(m_lfsr);
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // l0 is the LFSR value during the CLEAR cycle; cell k uses the value k+1 steps later
    function automatic logic [N-1:0] model(input logic [15:0] l0, input int wa, input int ha);
        logic [N-1:0] m = '1;
        logic [15:0]  l = l0;
        for (int y = 1; y < ha; y += 2) begin
            for (int x = 1; x < wa; x += 2) begin
                l = adv(l);
                m[40*y + x] = 1'b0;
                if (!(x == 1 && y == 1)) begin
                    if (y == 1)       m[40*y + x - 1]   = 1'b0;
                    else if (x == 1)  m[40*(y-1) + x]   = 1'b0;
                    else if (l[0])    m[40*(y-1) + x]   = 1'b0;
                    else              m[40*y + x - 1]   = 1'b0;
                end
            end
        end
        return m;
    endfunction

    function automatic int flood(input logic [N-1:0] m);
        bit vis [N];
        int q[$];
        int c = 0;
        int p, x, y, nx, ny, np;
        if (m[41]) return 0;
        vis[41] = 1'b1;
        q.push_back(41);
        while (q.size() > 0) begin
            p = q.pop_front();
            x = p % 40;
            y = p / 40;
            if ((x % 2 == 1) && (y % 2 == 1)) c++;
            for (int d = 0; d < 4; d++) begin
                nx = x; ny = y;
                case (d)
                    0: nx = x - 1;
                    1: nx = x + 1;
                    2: ny = y - 1;
                    default: ny = y + 1;
                endcase
                if (nx >= 0 && nx < 40 && ny >= 0 && ny < 30) begin
                    np = ny*40 + nx;
                    if (!m[np] && !vis[np]) begin
                        vis[np] = 1'b1;
                        q.push_back(np);
                    end
                end
            end
        end
        return c;
    endfunction

    task automatic run(input string nm, input logic [1:0] level, input int wa, input int ha,
                       input int inj, output logic [N-1:0] got);
        int nc      = (wa/2) * (ha/2);
        int busy_n  = 0;
        int done_at = -1;
        int done_n  = 0;
        int zeros   = 0;
        int oob     = 0;
        int pil     = 0;
        int edge_nz = 0;
        logic [15:0]  l0;
        logic [N-1:0] exp_map;
        lvl   = level;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l0 = m_lfsr;
        for (int k = 0; k <= nc + 8; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k == inj) begin
                start = 1'b1;
                lvl   = 2'b10;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        got = map;
        exp_map = model(l0, wa, ha);
        for (int y = 0; y < 30; y++) begin
            for (int x = 0; x < 40; x++) begin
                if (!got[40*y + x]) begin
                    zeros++;
                    if (x >= wa || y >= ha) oob++;
                    if (x % 2 == 0 && y % 2 == 0) pil++;
                end
            end
        end
        if (wa == 16) begin
            for (int x = 1; x < 16; x++) if (got[40 + x])   edge_nz++;
            for (int y = 1; y < 12; y++) if (got[40*y + 1]) edge_nz++;
            chk({nm, ".row1_col1"}, edge_nz, 0);
        end
        chk({nm, ".busy_cycles"}, busy_n, nc + 1);
        chk({nm, ".done_cycle"}, done_at, nc + 1);
        chk({nm, ".done_pulses"}, done_n, 1);
        chk({nm, ".level"}, int'(lvl_o), (level == 2'b11) ? 2 : int'(level));
        chk({nm, ".zeros"}, zeros, 2*nc - 1);
        chk({nm, ".out_of_bounds"}, oob, 0);
        chk({nm, ".pillars"}, pil, 0);
        chk({nm, ".reachable"}, flood(got), nc);
        chk({nm, ".exact_map"}, int'(got == exp_map), 1);
    endtask

    logic [N-1:0] m_a, m_b, m_tmp;
    int           seen;

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst.map_ones", int'(&map), 1);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.level", int'(lvl_o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        run("easy", 2'b00, 16, 12, -1, m_a);
        run("hard11", 2'b11, 40, 30, -1, m_tmp);
        run("normal", 2'b01, 32, 24, -1, m_tmp);
        run("easy_inj", 2'b00, 16, 12, 20, m_tmp);

        // Abort a Hard run about 100 cycles in
        lvl   = 2'b10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midrst.map_ones", int'(&map), 1);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.level", int'(lvl_o), 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        @(negedge clk) rst = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("midrst.no_done", seen, 0);

        run("easy_after_rst", 2'b00, 16, 12, -1, m_a);
        repeat (5) @(posedge clk);
        #1;
        run("easy_phase2", 2'b00, 16, 12, -1, m_b);
        chk("rand.maps_differ", int'(m_a != m_b), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
